// File: rtl/fetch_predict.sv
// Fetch stage: PC register, tagged direct-mapped BTB, optional bimodal BHT, decode handshake.
// Define FETCH_BHT_EN to add the 2-bit counter table; otherwise a BTB hit alone predicts taken.
module fetch_predict #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned BTB_ENTRIES  = 16,
    parameter int unsigned BHT_ENTRIES  = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic        out_pred_taken,
    output logic [31:0] out_pred_next,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);
    localparam int unsigned BTB_IW = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W  = 30 - BTB_IW;

    typedef enum logic [1:0] {INIT, RUN, BUBBLE} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [31:0]            btb_target [BTB_ENTRIES];

    logic [BTB_IW-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    logic              hit, pred_taken;
    logic [31:0]       pred_next;

    assign lk_idx = pc[BTB_IW+1:2];
    assign lk_tag = pc[31:BTB_IW+2];
    assign up_idx = upd_pc[BTB_IW+1:2];
    assign up_tag = upd_pc[31:BTB_IW+2];
    assign hit    = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);

`ifdef FETCH_BHT_EN
    localparam int unsigned BHT_IW = $clog2(BHT_ENTRIES);

    logic [1:0]        bht [BHT_ENTRIES];
    logic [BHT_IW-1:0] bht_lk_idx, bht_up_idx;
    logic              unused_bits;

    assign bht_lk_idx  = pc[BHT_IW+1:2];
    assign bht_up_idx  = upd_pc[BHT_IW+1:2];
    assign pred_taken  = hit && bht[bht_lk_idx][1];
    assign unused_bits = ^upd_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else if (upd_valid) begin
            if (upd_taken && bht[bht_up_idx] != 2'b11)
                bht[bht_up_idx] <= bht[bht_up_idx] + 2'd1;
            else if (!upd_taken && bht[bht_up_idx] != 2'b00)
                bht[bht_up_idx] <= bht[bht_up_idx] - 2'd1;
        end
    end
`else
    logic unused_bits;

    assign pred_taken  = hit;
    assign unused_bits = ^{upd_pc[1:0], BHT_ENTRIES != 0};
`endif

    assign pred_next = pred_taken ? btb_target[lk_idx] : pc + 32'd4;

    // Without a BHT, a not-taken resolution is the only way to stop predicting a branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (upd_valid) begin
            if (upd_taken)
                btb_valid[up_idx] <= 1'b1;
`ifndef FETCH_BHT_EN
            else if (btb_tag[up_idx] == up_tag)
                btb_valid[up_idx] <= 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            btb_tag[up_idx]    <= up_tag;
            btb_target[up_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            pc    <= RESET_VECTOR;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        out_valid = 1'b0;
        case (state)
            INIT:   state_nxt = RUN;
            RUN: begin
                out_valid = !redirect_valid;
                if (out_valid && out_ready) pc_nxt = pred_next;
            end
            BUBBLE: state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
        if (redirect_valid) begin
            pc_nxt    = redirect_pc;
            state_nxt = BUBBLE;
        end
    end

    assign out_pc         = pc;
    assign out_pred_taken = pred_taken;
    assign out_pred_next  = pred_next;
endmodule

// File: tb/tb_fetch_predict.sv
// Directed bench for fetch_predict: a behavioural fetch model checked every cycle plus literal checkpoints.
// Compile with the same FETCH_BHT_EN setting as the design.
module tb_fetch_predict;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam int unsigned BTB_N = 16;
    localparam int unsigned BHT_N = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_valid, out_ready, out_pred_taken;
    logic [31:0] out_pc, out_pred_next;
    logic        redirect_valid, upd_valid, upd_taken;
    logic [31:0] redirect_pc, upd_pc, upd_target;

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    fetch_predict #(
        .RESET_VECTOR(RV),
        .BTB_ENTRIES (BTB_N),
        .BHT_ENTRIES (BHT_N)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_pred_taken(out_pred_taken),
        .out_pred_next (out_pred_next),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each BTB slot remembers the full PC that last trained it; m_wait counts non-valid cycles left.
    logic [31:0] m_pc;
    int          m_wait;
    bit          m_bv   [BTB_N];
    logic [31:0] m_bpc  [BTB_N];
    logic [31:0] m_btgt [BTB_N];
    int          m_cnt  [BHT_N];
    int          ms, mb;

    function automatic int slot(input logic [31:0] a);
        return int'((a / 4) % BTB_N);
    endfunction

    function automatic bit same_tag(input logic [31:0] a, input logic [31:0] b);
        return (a / (4 * BTB_N)) == (b / (4 * BTB_N));
    endfunction

    function automatic bit m_taken(input logic [31:0] a);
        bit h;
        h = m_bv[slot(a)] && same_tag(m_bpc[slot(a)], a);
`ifdef FETCH_BHT_EN
        return h && (m_cnt[int'((a / 4) % BHT_N)] >= 2);
`else
        return h;
`endif
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] a);
        return m_taken(a) ? m_btgt[slot(a)] : a + 32'd4;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc   = RV;
            m_wait = 1;
            for (int i = 0; i < BTB_N; i++) m_bv[i] = 1'b0;
            for (int i = 0; i < BHT_N; i++) m_cnt[i] = 1;
        end else begin
            if (redirect_valid) begin
                m_pc   = redirect_pc;
                m_wait = 1;
            end else if (m_wait > 0) begin
                m_wait = m_wait - 1;
            end else if (out_ready) begin
                m_pc = m_next(m_pc);
            end
            if (upd_valid) begin
                ms = slot(upd_pc);
                mb = int'((upd_pc / 4) % BHT_N);
                if (upd_taken) begin
                    m_bv[ms]   = 1'b1;
                    m_bpc[ms]  = upd_pc;
                    m_btgt[ms] = upd_target;
                end
`ifndef FETCH_BHT_EN
                else if (same_tag(m_bpc[ms], upd_pc)) m_bv[ms] = 1'b0;
`endif
                if (upd_taken) m_cnt[mb] = (m_cnt[mb] == 3) ? 3 : m_cnt[mb] + 1;
                else           m_cnt[mb] = (m_cnt[mb] == 0) ? 0 : m_cnt[mb] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && !done) begin
            chk("cyc_valid", {31'b0, out_valid}, {31'b0, (m_wait == 0) && !redirect_valid});
            chk("cyc_pc", out_pc, m_pc);
            chk("cyc_taken", {31'b0, out_pred_taken}, {31'b0, m_taken(m_pc)});
            chk("cyc_next", out_pred_next, m_next(m_pc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pc(input logic [31:0] a);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (out_valid && out_pc == a) found = 1'b1;
        end
        chk("reach_pc", {31'b0, found}, 32'd1);
    endtask

    task automatic redirect_to(input logic [31:0] a);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = a;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        #2;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_taken", {31'b0, out_pred_taken}, 32'd0);
        chk("rst_next", out_pred_next, 32'h4);
        repeat (2) step();
        rst = 1'b0; out_ready = 1'b1;

        // Sequential fetch
        @(negedge clk); chk("init_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk); chk("run_valid", {31'b0, out_valid}, 32'd1); chk("seq_pc0", out_pc, 32'h0);
        @(negedge clk); chk("seq_pc4", out_pc, 32'h4); chk("seq_next4", out_pred_next, 32'h8);
        @(negedge clk); chk("seq_pc8", out_pc, 32'h8);
        @(negedge clk); chk("seq_pc12", out_pc, 32'hC);

        // Decode stall at 0x10
        step(); out_ready = 1'b0;
        repeat (3) begin @(negedge clk); chk("stall_pc", out_pc, 32'h10); end
        step(); out_ready = 1'b1;
        step();
        @(negedge clk); chk("release_pc", out_pc, 32'h14);

        // Redirect while at 0x20
        wait_pc(32'h1C);
        step(); redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk); chk("redir_valid0", {31'b0, out_valid}, 32'd0); chk("redir_oldpc", out_pc, 32'h20);
        step(); redirect_valid = 1'b0;
        @(negedge clk); chk("bubble_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk); chk("redir_pc", out_pc, 32'h200); chk("redir_valid1", {31'b0, out_valid}, 32'd1);
        @(negedge clk); chk("redir_pc2", out_pc, 32'h204);

        // Train 0x40 -> 0x100 twice; the first update coincides with a redirect
        step();
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
        redirect_valid = 1'b1; redirect_pc = 32'h38;
        step(); redirect_valid = 1'b0;
        step(); upd_valid = 1'b0;
        wait_pc(32'h40);
        chk("train_taken", {31'b0, out_pred_taken}, 32'd1);
        chk("train_next", out_pred_next, 32'h100);
        @(negedge clk); chk("train_pc", out_pc, 32'h100);

        // Alias 0x80 shares the slot of 0x40 with a different tag
        redirect_to(32'h80);
        wait_pc(32'h80);
        chk("alias_taken", {31'b0, out_pred_taken}, 32'd0);
        chk("alias_next", out_pred_next, 32'h84);
        @(negedge clk); chk("alias_pc", out_pc, 32'h84);

        // Update and lookup of 0x60 in the same cycle
        redirect_to(32'h60);
        step();
        upd_valid = 1'b1; upd_pc = 32'h60; upd_taken = 1'b1; upd_target = 32'h300; out_ready = 1'b0;
        @(negedge clk);
        chk("same_valid", {31'b0, out_valid}, 32'd1);
        chk("same_old_taken", {31'b0, out_pred_taken}, 32'd0);
        chk("same_old_next", out_pred_next, 32'h64);
        step(); upd_valid = 1'b0;
        @(negedge clk);
        chk("same_new_taken", {31'b0, out_pred_taken}, 32'd1);
        chk("same_new_next", out_pred_next, 32'h300);

        // Four not-taken updates, then one taken, then an aliasing not-taken at 0xA0
        step(); upd_valid = 1'b1; upd_taken = 1'b0;
        repeat (3) step();
        step(); upd_valid = 1'b0;
        @(negedge clk); chk("nt_taken", {31'b0, out_pred_taken}, 32'd0);
        step(); upd_valid = 1'b1; upd_taken = 1'b1;
        step(); upd_pc = 32'hA0; upd_taken = 1'b0;
        step(); upd_valid = 1'b0;
        @(negedge clk);
`ifdef FETCH_BHT_EN
        chk("sat_no_wrap", {31'b0, out_pred_taken}, 32'd0);
`else
        chk("alias_no_clear", {31'b0, out_pred_taken}, 32'd1);
`endif
        out_ready = 1'b1;

        // Redirect again during BUBBLE
        step(); redirect_valid = 1'b1; redirect_pc = 32'h300;
        step(); redirect_pc = 32'h400;
        step(); redirect_valid = 1'b0;
        @(negedge clk); chk("rebub_valid", {31'b0, out_valid}, 32'd0); chk("rebub_pc", out_pc, 32'h400);
        @(negedge clk); chk("rebub_valid1", {31'b0, out_valid}, 32'd1);

        // PC wraps at the top of the address space
        redirect_to(32'hFFFF_FFFC);
        wait_pc(32'hFFFF_FFFC);
        chk("wrap_next", out_pred_next, 32'h0);
        @(negedge clk); chk("wrap_pc", out_pc, 32'h0);

        // Asynchronous reset mid-stream clears BTB and PC without a clock edge
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_pc", out_pc, 32'h0);
        chk("arst_next", out_pred_next, 32'h4);
        repeat (2) step();
        rst = 1'b0;
        redirect_to(32'h40);
        wait_pc(32'h40);
        chk("arst_btb_taken", {31'b0, out_pred_taken}, 32'd0);
        chk("arst_btb_next", out_pred_next, 32'h44);

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
